// File: rtl/multicycle_controller.sv
// Multicycle processor sequencing controller: FETCH/DECODE/EXEC/WRITEBACK FSM,
// NZCV flag register, and condition-gated datapath enables.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         rd,
    input  logic [3:0]         alu_flags,
    input  logic               cond_ex,
    output logic [3:0]         flags,
    output logic               pc_write,
    output logic               adr_src,
    output logic               ir_write,
    output logic               mem_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q;
    logic       cond_q;
    logic       no_write_q;

    logic       next_pc, branch, reg_w, mem_w, ir_w, alu_op;
    logic [3:0] cmd;
    logic       cmd_known, cmd_cv, dp_no_write;
    logic       fw_nz, fw_cv;

    assign cmd = funct[4:1];

    // Command classification: which opcodes are real writers, which touch C/V.
    always_comb begin
        cmd_known = 1'b0;
        cmd_cv    = 1'b0;
        case (cmd)
            4'b0100: begin cmd_known = 1'b1; cmd_cv = 1'b1; end
            4'b0010: begin cmd_known = 1'b1; cmd_cv = 1'b1; end
            4'b0000: cmd_known = 1'b1;
            4'b1100: cmd_known = 1'b1;
            4'b1010: cmd_cv = 1'b1;
            default: ;
        endcase
    end

    // no_write only applies to data-processing, so load funct bits never suppress writeback.
    assign dp_no_write = (op == 2'b00) & ~cmd_known;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            flags_q    <= 4'b0000;
            cond_q     <= 1'b0;
            no_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                cond_q     <= cond_ex;
                no_write_q <= dp_no_write;
            end
            if (cond_q) begin
                if (fw_nz) flags_q[3:2] <= alu_flags[3:2];
                if (fw_cv) flags_q[1:0] <= alu_flags[1:0];
            end
        end
    end

    always_comb begin
        state_d    = FETCH;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        alu_op     = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        case (state_q)
            FETCH: begin
                state_d    = DECODE;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_w       = 1'b1;
                next_pc    = 1'b1;
            end
            DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                state_d   = funct[0] ? MEMRD : MEMWR;
                alu_src_b = 2'b01;
            end
            MEMRD: begin
                state_d = MEMWB;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            EXECR: begin
                state_d = ALUWB;
                alu_op  = 1'b1;
            end
            EXECI: begin
                state_d   = ALUWB;
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            ALUWB: reg_w = 1'b1;
            BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        alu_control = 2'b00;
        if (alu_op) begin
            case (cmd)
                4'b0010: alu_control = 2'b01;
                4'b0000: alu_control = 2'b10;
                4'b1100: alu_control = 2'b11;
                4'b1010: alu_control = 2'b01;
                default: alu_control = 2'b00;
            endcase
        end
    end

    assign fw_nz = alu_op & funct[0];
    assign fw_cv = fw_nz & cmd_cv;

    // Architectural writes use the condition latched in DECODE, never the live cond_ex.
    assign mem_write = ~rst & mem_w & cond_q;
    assign reg_write = ~rst & reg_w & cond_q & ~no_write_q;
    assign ir_write  = ~rst & ir_w;
    assign pc_write  = ~rst & (next_pc |
                       (cond_q & (branch | (reg_w & (rd == 4'd15) & ~no_write_q))));

    assign flags   = flags_q;
    assign imm_src = op;
    assign reg_src = {op == 2'b01, op == 2'b10};
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instructions plus
// randomized instruction streams against an instruction-level reference model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       cond_ex;
    logic [3:0] flags;
    logic       pc_write, adr_src, ir_write, mem_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_control, imm_src, reg_src;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    logic [3:0] model_flags = 4'b0000;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .cond_ex(cond_ex), .flags(flags),
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .imm_src(imm_src), .reg_src(reg_src), .state(state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Static mux settings per state number, packed {adr_src, result_src, src_a, src_b}.
    function automatic logic [6:0] muxFor(input int s);
        case (s)
            0: return {1'b0, 2'b10, 2'b01, 2'b10};
            1: return {1'b0, 2'b10, 2'b01, 2'b10};
            2: return {1'b0, 2'b00, 2'b00, 2'b01};
            3: return {1'b1, 2'b00, 2'b00, 2'b00};
            4: return {1'b0, 2'b01, 2'b00, 2'b00};
            5: return {1'b1, 2'b00, 2'b00, 2'b00};
            6: return {1'b0, 2'b00, 2'b00, 2'b00};
            7: return {1'b0, 2'b00, 2'b00, 2'b01};
            8: return {1'b0, 2'b00, 2'b00, 2'b00};
            default: return {1'b0, 2'b10, 2'b10, 2'b01};
        endcase
    endfunction

    function automatic logic [1:0] aluFor(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // One cycle of reset: write enables must be held low, then everything clears.
    task automatic resetCycle();
        @(negedge clk);
        rst = 1'b1;
        cond_ex = 1'($urandom);
        alu_flags = 4'($urandom);
        #1;
        checkOutput("rst_pc_write", 32'(pc_write), 0);
        checkOutput("rst_ir_write", 32'(ir_write), 0);
        checkOutput("rst_mem_write", 32'(mem_write), 0);
        checkOutput("rst_reg_write", 32'(reg_write), 0);
        @(posedge clk);
        #1;
        checkOutput("rst_state", 32'(state), 0);
        checkOutput("rst_flags", 32'(flags), 0);
        model_flags = 4'b0000;
    endtask

    // Runs one instruction to completion (or aborts with reset at cycle abort_at).
    task automatic applyStimulus(input logic [1:0] i_op, input logic [5:0] i_funct,
                                 input logic [3:0] i_rd, input logic i_cond,
                                 input logic [3:0] exec_flags, input int abort_at);
        int path[$];
        logic [3:0] cmd;
        logic dp, nw, writer, exp_pc, exp_reg, exp_mem;
        logic [6:0] m;
        int s;
        cmd = i_funct[4:1];
        dp  = (i_op == 2'b00);
        nw  = dp && !(cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100});
        path = {0, 1};
        case (i_op)
            2'b00: path = {0, 1, i_funct[5] ? 7 : 6, 8};
            2'b01: path = i_funct[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'b10: path = {0, 1, 9};
            default: ;
        endcase
        for (int k = 0; k < path.size(); k++) begin
            if (k == abort_at) begin
                resetCycle();
                return;
            end
            s = path[k];
            @(negedge clk);
            rst = 1'b0;
            op = i_op;
            funct = i_funct;
            rd = i_rd;
            cond_ex = (k == 1) ? i_cond : ~i_cond;
            alu_flags = (s == 6 || s == 7) ? exec_flags : 4'($urandom);
            #1;
            writer  = (s == 4 || s == 8);
            exp_reg = writer && i_cond && !nw;
            exp_mem = (s == 5) && i_cond;
            exp_pc  = (k == 0) || ((s == 9) && i_cond) || (exp_reg && i_rd == 4'd15);
            m = muxFor(s);
            checkOutput("state", 32'(state), 32'(s));
            checkOutput("pc_write", 32'(pc_write), 32'(exp_pc));
            checkOutput("ir_write", 32'(ir_write), 32'(k == 0));
            checkOutput("mem_write", 32'(mem_write), 32'(exp_mem));
            checkOutput("reg_write", 32'(reg_write), 32'(exp_reg));
            checkOutput("muxes", 32'({adr_src, result_src, alu_src_a, alu_src_b}), 32'(m));
            checkOutput("alu_control", 32'(alu_control),
                        32'((s == 6 || s == 7) ? aluFor(cmd) : 2'b00));
            checkOutput("flags", 32'(flags), 32'(model_flags));
            checkOutput("imm_reg_src", 32'({imm_src, reg_src}),
                        32'({i_op, i_op == 2'b01, i_op == 2'b10}));
            if ((s == 6 || s == 7) && i_cond && i_funct[0]) begin
                model_flags[3:2] = exec_flags[3:2];
                if (cmd inside {4'b0100, 4'b0010, 4'b1010})
                    model_flags[1:0] = exec_flags[1:0];
            end
        end
    endtask

    initial begin
        rst = 1'b1; op = 2'b00; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0; cond_ex = 1'b0;
        resetCycle();
        resetCycle();
        applyStimulus(2'b00, 6'b101001, 4'd1, 1'b0, 4'b0101, -1);
        applyStimulus(2'b00, 6'b101001, 4'd1, 1'b1, 4'b1010, -1);
        applyStimulus(2'b01, 6'b011001, 4'd2, 1'b1, 4'b0000, -1);
        applyStimulus(2'b01, 6'b011000, 4'd3, 1'b1, 4'b0000, -1);
        applyStimulus(2'b01, 6'b011000, 4'd3, 1'b0, 4'b0000, -1);
        applyStimulus(2'b00, 6'b010101, 4'd4, 1'b1, 4'b0111, -1);
        applyStimulus(2'b00, 6'b001000, 4'd15, 1'b1, 4'b0000, -1);
        applyStimulus(2'b00, 6'b010100, 4'd15, 1'b1, 4'b0000, -1);
        applyStimulus(2'b10, 6'b000000, 4'd0, 1'b1, 4'b0000, -1);
        applyStimulus(2'b10, 6'b000000, 4'd0, 1'b0, 4'b0000, -1);
        applyStimulus(2'b11, 6'b111111, 4'd15, 1'b1, 4'b0000, -1);
        applyStimulus(2'b00, 6'b001001, 4'd5, 1'b1, 4'b1111, -1);
        applyStimulus(2'b01, 6'b011001, 4'd6, 1'b1, 4'b0000, 3);
        for (int n = 0; n < 300; n++) begin
            logic [1:0] r_op;
            logic [5:0] r_funct;
            logic [3:0] r_rd;
            r_op = 2'($urandom);
            r_funct = 6'($urandom);
            if ($urandom_range(0, 1) == 0)
                r_funct[4:1] = ($urandom_range(0, 1) == 0) ? 4'b1010 : 4'b0100;
            r_rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            applyStimulus(r_op, r_funct, r_rd, 1'($urandom), 4'($urandom),
                          ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 2)) : -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Sequencing control unit for the multicycle processor core. It holds the NZCV flag register and steps each instruction through a fetch/decode/execute/writeback state machine. It drives every datapath mux and write enable. Architectural writes are gated by the condition-check result; that result is computed outside this block from the `flags` output and the instruction cond field.

Parameters:
- STATE_W, 4, width of the state encoding / debug port

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  2  instr[27:26]
- funct  in  6  instr[25:20] (funct[5]=I, funct[4:1]=cmd, funct[0]=S or L)
- rd  in  4  instr[15:12]
- alu_flags  in  4  {N,Z,C,V} from ALU, current cycle
- cond_ex  in  1  condition-pass from external checker (driven from flags output)
- flags  out  4  stored {N,Z,C,V}
- pc_write  out  1  PC register enable
- adr_src  out  1  0=PC, 1=ALU result register
- ir_write  out  1  instruction register enable
- mem_write  out  1  data memory write enable
- reg_write  out  1  register file write enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  00=RD1, 01=PC, 10=ALUOut
- alu_src_b  out  2  00=RD2/shifted, 01=ExtImm, 10=constant 4
- alu_control  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- imm_src  out  2  equals op
- reg_src  out  2  {op==01, op==10}
- state  out  STATE_W  current state (debug)

Behaviour:
- Reset (rst=1 at edge):
  - state<=FETCH(0), flags<=0000, cond_q<=0.
  - While rst=1, pc_write/ir_write/mem_write/reg_write are forced 0.
- States: FETCH0, DECODE1, MEMADR2, MEMRD3, MEMWB4, MEMWR5, EXECR6, EXECI7, ALUWB8, BRANCH9.
  - Encodings 10-15 go to FETCH on the next edge with all enables 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE on op:
    - 01 -> MEMADR
    - 00 with funct[5]=0 -> EXECR
    - 00 with funct[5]=1 -> EXECI
    - 10 -> BRANCH
    - 11 -> FETCH (undefined instruction, no writes)
  - MEMADR: funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD->MEMWB->FETCH; MEMWR->FETCH.
  - EXECR/EXECI->ALUWB->FETCH; BRANCH->FETCH.
- cond_q: captures cond_ex at the end of DECODE only. All later gating uses cond_q, so a flag update in EXEC does not affect its own instruction.
- Per-state raw controls (unlisted fields = 0):
  - FETCH: adr_src0, a=01, b=10, res=10, ir_write=1, next_pc=1.
  - DECODE: a=01, b=10, res=10.
  - MEMADR: a=00, b=01.
  - MEMRD: adr_src1, res=00.
  - MEMWB: res=01, reg_w=1.
  - MEMWR: adr_src1, mem_w=1.
  - EXECR: a=00, b=00, alu_op=1.
  - EXECI: a=00, b=01, alu_op=1.
  - ALUWB: res=00, reg_w=1.
  - BRANCH: a=10, b=01, res=10, branch=1.
- ALU decode:
  - alu_op=0 -> ADD.
  - alu_op=1, by funct[4:1]: 0100 ADD; 0010 SUB; 0000 AND; 1100 ORR; 1010 CMP -> SUB with no_write=1; any other value -> ADD with no_write=1.
- Flag write enables:
  - fw_nz = alu_op & funct[0].
  - fw_cv = fw_nz & cmd in {ADD, SUB, CMP}.
- Flag update, at the edge ending EXECR/EXECI, only when cond_q=1:
  - flags[3:2] <= alu_flags[3:2] if fw_nz.
  - flags[1:0] <= alu_flags[1:0] if fw_cv.
- Gated outputs:
  - mem_write = mem_w & cond_q.
  - reg_write = reg_w & cond_q & ~no_write_q. no_write_q is latched with cond_q in DECODE.
  - pc_write = next_pc | (cond_q & (branch | (reg_w & rd==15 & ~no_write_q))).
- Latency in cycles (FETCH..last state): LDR 5; STR 4; data-processing 4; B 3.

Test Plan:
1. Reset, then op=00 funct=101001 (ADD imm, S). Sequence FETCH,DECODE,EXECI,ALUWB = states 0,1,7,8. alu_flags=1010 with cond_ex=1 -> flags=1010 after EXECI. reg_write=1 only in ALUWB.
2. cond_ex=0 in DECODE, same instruction: flags stay 0000, reg_write=0 in ALUWB. cond_ex changing to 1 after DECODE has no effect.
3. LDR (op=01 funct[0]=1): states 0,1,2,3,4. adr_src=1 in MEMRD. reg_write=1 in MEMWB. STR (funct[0]=0): states 0,1,2,5 with mem_write=1 in MEMWR only.
4. CMP (funct=010101): flags updated to alu_flags, alu_control=01, reg_write=0 in ALUWB. ADD with rd=15 and cond_q=1 -> pc_write=1 in ALUWB.
5. B (op=10) with cond_q=1: states 0,1,9, pc_write=1 in BRANCH. With cond_q=0, pc_write=0 in BRANCH. pc_write=1 in every FETCH.
6. Assert rst mid-MEMRD: next state=0, flags=0000, all write enables 0 while rst=1. op=11 from DECODE -> FETCH with no writes.
